// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception/interrupt controller
package exc_pkg;

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2,
    ST_KERNEL = 2'd3
  } state_e;

  localparam int          CAUSE_EXC   = 0;
  localparam logic [31:0] VEC_EXC_DEF = 32'h8000_0008;
  localparam logic [31:0] VEC_IRQ_DEF = 32'h8000_0004;

  // Channel index width; a single channel still needs one bit to stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder over the armed interrupt lines
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the last hit, the lowest index, is what remains.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// rtl/exc_irq_ctrl.sv - trap sequencer: arbitrate, drain pipeline, vector, track kernel mode
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int              N_IRQ   = 4,
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] VEC_EXC = PC_W'(VEC_EXC_DEF),
  parameter logic [PC_W-1:0] VEC_IRQ = PC_W'(VEC_IRQ_DEF),
  parameter int              CAUSE_W = 1 + idx_w(N_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IRQ-1:0]   irq,
  input  logic               exc_req,
  input  logic [PC_W-1:0]    pc_cur,
  input  logic               mask_we,
  input  logic [N_IRQ-1:0]   mask_wdata,
  input  logic               eret,
  input  logic               flush_ack,
  output logic               flush_req,
  output logic               vec_valid,
  output logic [PC_W-1:0]    vec_pc,
  output logic [PC_W-1:0]    epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               ker,
  output logic [N_IRQ-1:0]   mask,
  output logic [N_IRQ-1:0]   pending,
  output logic               double_fault
);

  localparam int IDX_W = CAUSE_W - 1;

  state_e             state_q, state_d;
  logic [N_IRQ-1:0]   irq_q, pending_q, pending_d, mask_q, mask_d;
  logic [N_IRQ-1:0]   irq_rise, take_clr, armed;
  logic [PC_W-1:0]    epc_q, epc_d, vec_pc_q, vec_pc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               df_q, df_d;
  logic               enc_valid, trap;
  logic [IDX_W-1:0]   enc_idx;

  assign armed = pending_q & mask_q;

  irq_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_prio_enc (
    .req   (armed),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign trap = (state_q == ST_USER) && (exc_req || enc_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_USER;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_USER:   if (trap)      state_d = ST_DRAIN;
      ST_DRAIN:  if (flush_ack) state_d = ST_VECTOR;
      ST_VECTOR:                state_d = ST_KERNEL;
      ST_KERNEL: if (eret)      state_d = ST_USER;
      default:                  state_d = ST_USER;
    endcase
  end

  always_comb begin
    epc_d    = epc_q;
    cause_d  = cause_q;
    vec_pc_d = vec_pc_q;
    df_d     = df_q;
    take_clr = '0;
    mask_d   = mask_we ? mask_wdata : mask_q;
    irq_rise = irq & ~irq_q;
    if (trap) begin
      epc_d   = pc_cur;
      cause_d = exc_req ? CAUSE_W'(CAUSE_EXC) : {1'b1, enc_idx};
    end
    // Target is registered on leaving DRAIN so it is stable for the whole VECTOR cycle.
    if (state_q == ST_DRAIN && flush_ack)
      vec_pc_d = cause_q[CAUSE_W-1] ? VEC_IRQ : VEC_EXC;
    if (state_q == ST_VECTOR && cause_q[CAUSE_W-1])
      take_clr = N_IRQ'(1) << cause_q[IDX_W-1:0];
    if (state_q == ST_KERNEL && exc_req)
      df_d = 1'b1;
    // A fresh edge on the channel being taken must not be lost.
    pending_d = (pending_q & ~take_clr) | irq_rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      epc_q     <= '0;
      vec_pc_q  <= '0;
      cause_q   <= '0;
      df_q      <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      epc_q     <= epc_d;
      vec_pc_q  <= vec_pc_d;
      cause_q   <= cause_d;
      df_q      <= df_d;
    end
  end

  always_comb begin
    flush_req    = (state_q == ST_DRAIN);
    vec_valid    = (state_q == ST_VECTOR);
    ker          = (state_q == ST_VECTOR) || (state_q == ST_KERNEL);
    vec_pc       = vec_pc_q;
    epc          = epc_q;
    cause        = cause_q;
    mask         = mask_q;
    pending      = pending_q;
    double_fault = df_q;
  end

endmodule
